mul_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one repeated-addition multiplier datapath (registers A, B, P; P += A, B -= 1 until B == 0) among N_REQ requesters. It accepts one request at a time and captures that requester's operands. It then drives the datapath's load, clear and decrement strobes over a single shared operand bus and returns the product tagged with the requester index. It sits between the client blocks and the multiplier datapath, replacing a single-client controller.

---
 rtl/mul_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mul_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_arbiter.sv
// Round-robin arbiter/sequencer sharing one repeated-addition multiplier datapath
// (P += A, B -= 1 until B == 0) among N_REQ requesters, returning id-tagged products.
module mul_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16,
    parameter int IDW   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] a_flat,
    input  logic [N_REQ*WIDTH-1:0] b_flat,
    output logic [N_REQ-1:0]       gnt,
    output logic                   busy,
    output logic [WIDTH-1:0]       dp_data,
    output logic                   ld_a,
    output logic                   ld_b,
    output logic                   clr_p,
    output logic                   ld_p,
    output logic                   dec_b,
    input  logic                   eqz,
    input  logic [WIDTH-1:0]       p_in,
    output logic [WIDTH-1:0]       result,
    output logic [IDW-1:0]         result_id,
    output logic                   result_valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_LOAD_A,
        S_LOAD_B,
        S_ADD,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_cur_id;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_result;
    logic [IDW-1:0]   r_result_id;

    logic [WIDTH-1:0] w_a_arr [N_REQ];
    logic [WIDTH-1:0] w_b_arr [N_REQ];
    logic             w_found;
    logic [IDW-1:0]   w_win;
    logic [IDW-1:0]   w_ptr_nxt;
    logic             w_accept;
    logic             w_capture;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign w_a_arr[gi] = a_flat[gi*WIDTH +: WIDTH];
        assign w_b_arr[gi] = b_flat[gi*WIDTH +: WIDTH];
    end

    // Rotating search: candidate k is (ptr + k) mod N_REQ, first set bit wins.
    always_comb begin : p_arb
        logic [IDW:0]   sum;
        logic [IDW-1:0] idx;
        w_found = 1'b0;
        w_win   = '0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, r_ptr} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(N_REQ)) begin
                sum = sum - (IDW+1)'(N_REQ);
            end
            idx = sum[IDW-1:0];
            if (!w_found && req[idx]) begin
                w_found = 1'b1;
                w_win   = idx;
            end
        end
    end

    assign w_ptr_nxt = (w_win == IDW'(N_REQ-1)) ? '0 : w_win + 1'b1;

    // NOTE: every combinational output gets a default before the case, so no
    // path through the block leaves a signal unassigned and no latch appears.
    always_comb begin
        w_state_nxt  = r_state;
        gnt          = '0;
        busy         = 1'b1;
        dp_data      = '0;
        ld_a         = 1'b0;
        ld_b         = 1'b0;
        clr_p        = 1'b0;
        ld_p         = 1'b0;
        dec_b        = 1'b0;
        result_valid = 1'b0;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (w_found) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                gnt[r_cur_id] = 1'b1;
                w_state_nxt   = S_LOAD_A;
            end
            S_LOAD_A: begin
                dp_data     = r_op_a;
                ld_a        = 1'b1;
                w_state_nxt = S_LOAD_B;
            end
            S_LOAD_B: begin
                dp_data     = r_op_b;
                ld_b        = 1'b1;
                clr_p       = 1'b1;
                w_state_nxt = S_ADD;
            end
            S_ADD: begin
                ld_p  = !eqz;
                dec_b = !eqz;
                if (eqz) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                result_valid = 1'b1;
                if (w_found) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_GRANT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                busy        = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: operand and result registers are reset as well, so an aborted job
    // leaves no stale product or id visible on the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_cur_id    <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_result    <= '0;
            r_result_id <= '0;
        end else begin
            if (w_accept) begin
                r_op_a   <= w_a_arr[w_win];
                r_op_b   <= w_b_arr[w_win];
                r_cur_id <= w_win;
                r_ptr    <= w_ptr_nxt;
            end
            if (w_capture) begin
                r_result    <= p_in;
                r_result_id <= r_cur_id;
            end
        end
    end

    assign result    = r_result;
    assign result_id = r_result_id;

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter with a behavioural multiplier datapath
// (A, B, P registers) wired to the strobes, driven by directed job vectors.
module tb_mul_arbiter;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] a_flat;
    logic [N*W-1:0] b_flat;
    logic [N-1:0]   gnt;
    logic           busy;
    logic [W-1:0]   dp_data;
    logic           ld_a, ld_b, clr_p, ld_p, dec_b;
    logic           eqz;
    logic [W-1:0]   p_in;
    logic [W-1:0]   result;
    logic [IDW-1:0] result_id;
    logic           result_valid;

    mul_arbiter #(.N_REQ(N), .WIDTH(W), .IDW(IDW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .a_flat       (a_flat),
        .b_flat       (b_flat),
        .gnt          (gnt),
        .busy         (busy),
        .dp_data      (dp_data),
        .ld_a         (ld_a),
        .ld_b         (ld_b),
        .clr_p        (clr_p),
        .ld_p         (ld_p),
        .dec_b        (dec_b),
        .eqz          (eqz),
        .p_in         (p_in),
        .result       (result),
        .result_id    (result_id),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    // Datapath model: A, B, P registers driven by the strobes.
    logic [W-1:0] m_a, m_b, m_p;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_a <= '0;
            m_b <= '0;
            m_p <= '0;
        end else begin
            if (ld_a)  m_a <= dp_data;
            if (ld_b)  m_b <= dp_data;
            if (dec_b) m_b <= m_b - 1'b1;
            if (clr_p)     m_p <= '0;
            else if (ld_p) m_p <= m_p + m_a;
        end
    end
    assign eqz  = (m_b == '0);
    assign p_in = m_p;

    int n_cmp = 0;
    int n_err = 0;
    int ldp_cnt, decb_cnt, g2_cnt, r2_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock and sample 1ns after the edge; tallies strobe activity.
    task automatic tick();
        @(posedge clk);
        #1;
        if (ld_p)  ldp_cnt++;
        if (dec_b) decb_cnt++;
        if (gnt[2]) g2_cnt++;
        if (result_valid && result_id == 2'd2) r2_cnt++;
    endtask

    task automatic set_ops(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        a_flat[id*W +: W] = a;
        b_flat[id*W +: W] = b;
    endtask

    task automatic wait_valid(input int max_cyc, output int n);
        n = 0;
        while (!result_valid && n < max_cyc) begin
            tick();
            n++;
        end
    endtask

    task automatic run_job(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp);
        int n;
        set_ops(id, a, b);
        req[id]  = 1'b1;
        ldp_cnt  = 0;
        decb_cnt = 0;
        tick();
        check($sformatf("job%0d gnt", id), 32'(gnt), 32'(1 << id));
        check($sformatf("job%0d busy", id), 32'(busy), 32'd1);
        req[id] = 1'b0;
        wait_valid(int'(b) + 20, n);
        check($sformatf("job%0d latency", id), 32'(n), 32'(int'(b) + 4));
        check($sformatf("job%0d result", id), 32'(result), 32'(exp));
        check($sformatf("job%0d result_id", id), 32'(result_id), 32'(id));
        check($sformatf("job%0d ld_p count", id), 32'(ldp_cnt), 32'(b));
        check($sformatf("job%0d dec_b count", id), 32'(decb_cnt), 32'(b));
        tick();
        check($sformatf("job%0d valid pulse", id), 32'(result_valid), 32'd0);
        check($sformatf("job%0d idle", id), 32'(busy), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " gnt"}, 32'(gnt), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " dp_data"}, 32'(dp_data), 32'd0);
        check({tag, " strobes"}, 32'({ld_a, ld_b, clr_p, ld_p, dec_b}), 32'd0);
        check({tag, " result"}, 32'(result), 32'd0);
        check({tag, " result_id"}, 32'(result_id), 32'd0);
        check({tag, " result_valid"}, 32'(result_valid), 32'd0);
    endtask

    typedef struct {
        int           id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_result;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int gcount;
        int last_gid;
        int exp_seq [4];

        vecs[0] = '{0, 16'd15,     16'd9, 16'd135};
        vecs[1] = '{1, 16'd7,      16'd0, 16'd0};
        vecs[2] = '{2, 16'hFFFF,   16'd2, 16'hFFFE};
        vecs[3] = '{0, 16'd0,      16'd5, 16'd0};
        vecs[4] = '{1, 16'd3,      16'd7, 16'd21};
        vecs[5] = '{3, 16'd12,     16'd1, 16'd12};
        exp_seq = '{1, 2, 1, 2};

        rst_n  = 1'b0;
        req    = '0;
        a_flat = '0;
        b_flat = '0;
        ldp_cnt = 0; decb_cnt = 0; g2_cnt = 0; r2_cnt = 0;
        #1;
        check_all_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_all_zero("post-reset");

        // Single-requester jobs; the last one (id 3) wraps ptr back to 0.
        for (int i = 0; i < 6; i++) begin
            run_job(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].exp_result);
        end

        // All four request together: grants 0..3, DONE goes straight to GRANT.
        for (int i = 0; i < N; i++) set_ops(i, W'(i + 2), 16'd3);
        req = 4'hF;
        tick();
        for (int k = 0; k < N; k++) begin
            check($sformatf("all4 gnt order %0d", k), 32'(gnt), 32'(1 << k));
            req[k] = 1'b0;
            wait_valid(30, n);
            check($sformatf("all4 result %0d", k), 32'(result), 32'((k + 2) * 3));
            check($sformatf("all4 result_id %0d", k), 32'(result_id), 32'(k));
            tick();
        end
        check("all4 idle after", 32'(busy), 32'd0);

        // Fairness: req[1] and req[2] held high, grants alternate.
        set_ops(1, 16'd4, 16'd2);
        set_ops(2, 16'd5, 16'd1);
        req = 4'b0110;
        gcount = 0;
        last_gid = 0;
        n = 0;
        while (gcount < 4 && n < 200) begin
            tick();
            n++;
            if (result_valid) begin
                check("fair result_id", 32'(result_id), 32'(last_gid));
                check("fair result", 32'(result), (last_gid == 1) ? 32'd8 : 32'd5);
            end
            if (gnt != '0) begin
                check($sformatf("fair gnt %0d", gcount), 32'(gnt), 32'(1 << exp_seq[gcount]));
                last_gid = exp_seq[gcount];
                gcount++;
                if (gcount == 4) req = '0;
            end
        end
        check("fair grant count", 32'(gcount), 32'd4);
        wait_valid(30, n);
        check("fair last result_id", 32'(result_id), 32'd2);
        check("fair last result", 32'(result), 32'd5);
        tick();
        check("fair idle", 32'(busy), 32'd0);

        // Reset in the middle of a long ADD phase (ptr is nonzero at this point).
        set_ops(1, 16'd5, 16'd40);
        req[1] = 1'b1;
        tick();
        check("rst job gnt", 32'(gnt), 32'b0010);
        req[1] = 1'b0;
        repeat (10) tick();
        check("rst job in ADD", 32'(ld_p), 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid-ADD reset");
        @(negedge clk);
        check_all_zero("held reset");
        @(negedge clk);
        rst_n = 1'b1;
        // ptr=0 after reset: 0 beats 3 although the pre-reset ptr would pick 3.
        set_ops(0, 16'd3, 16'd4);
        set_ops(3, 16'd9, 16'd3);
        req = 4'b1001;
        tick();
        check("post-rst gnt first", 32'(gnt), 32'b0001);
        req[0] = 1'b0;
        wait_valid(30, n);
        check("post-rst latency", 32'(n), 32'd8);
        check("post-rst result0", 32'(result), 32'd12);
        check("post-rst id0", 32'(result_id), 32'd0);
        tick();
        check("post-rst gnt second", 32'(gnt), 32'b1000);
        req[3] = 1'b0;
        wait_valid(30, n);
        check("post-rst result3", 32'(result), 32'd27);
        check("post-rst id3", 32'(result_id), 32'd3);
        tick();
        check("post-rst idle", 32'(busy), 32'd0);

        // req[2] pulses during another job's ADD and is withdrawn before arbitration.
        g2_cnt = 0;
        r2_cnt = 0;
        set_ops(0, 16'd11, 16'd6);
        set_ops(2, 16'd2, 16'd2);
        req[0] = 1'b1;
        tick();
        check("wd gnt", 32'(gnt), 32'b0001);
        req[0] = 1'b0;
        repeat (5) tick();
        req[2] = 1'b1;
        tick();
        tick();
        req[2] = 1'b0;
        wait_valid(30, n);
        check("wd result", 32'(result), 32'd66);
        check("wd result_id", 32'(result_id), 32'd0);
        repeat (4) tick();
        check("wd no gnt2", 32'(g2_cnt), 32'd0);
        check("wd no result id2", 32'(r2_cnt), 32'd0);
        check("wd idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
